// File: rtl/debounce_multi_channel_1.sv
// -----------------------------------------------------------------------------
// debounce_multi_channel_1
//
// Multi-channel switch debouncer. Each channel runs a synchroniser followed by
// a symmetric press/release filter: the debounced level only follows the
// synchronised input once it has disagreed with the level for 2^CNT_BITS
// consecutive cycles. Any cycle of agreement restarts the settle window.
//
// Parameters
//   CHANNELS    number of independent switch inputs (>= 1)
//   CNT_BITS    settle counter width, window N = 2^CNT_BITS cycles (>= 1)
//   SYNC_STAGES synchroniser depth per channel (>= 2)
//   ACTIVE_HIGH 1: pin high = pressed, 0: pin low = pressed
//
// Ports
//   clk          system clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   buttons      raw bouncing switch pins, asynchronous to clk
//   level        debounced state per channel, 1 = pressed
//   pressed      one-cycle pulse when level[i] rises
//   released     one-cycle pulse when level[i] falls
//   result       copy of level for the downstream control logic
//   result_ready one-cycle pulse whenever any press/release pulse fires
// -----------------------------------------------------------------------------
module debounce_multi_channel_1 #(
  parameter int CHANNELS    = 4,
  parameter int CNT_BITS    = 23,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] buttons,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] result,
  output logic                result_ready
);

  // Pin value that means "not pressed"; the synchroniser resets to it so that
  // leaving reset never looks like an input change.
  localparam logic                   IDLE_PIN   = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [SYNC_STAGES-1:0] SYNC_RESET = {SYNC_STAGES{IDLE_PIN}};
  localparam logic [CNT_BITS-1:0]    CNT_LAST   = '1;  // N-1

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CNT_BITS-1:0]    cnt_q  [CHANNELS];
  logic [CNT_BITS-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    sync_pressed;
  logic [CHANNELS-1:0]    level_q, level_d;
  logic [CHANNELS-1:0]    pressed_q, pressed_d;
  logic [CHANNELS-1:0]    released_q, released_d;
  logic                   ready_q;

  // Last synchroniser stage, polarity-corrected so 1 always means pressed.
  always_comb begin
    sync_pressed = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_pressed[i] = sync_q[i][SYNC_STAGES-1] ^ IDLE_PIN;
    end
  end

  // Per-channel settle logic. The counter being non-zero is the SETTLING state;
  // reaching N-1 toggles the level instead of incrementing, so it never wraps.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    level_d    = level_q;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_pressed[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]    = sync_pressed[i];
          pressed_d[i]  = sync_pressed[i];
          released_d[i] = ~sync_pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-channel counter and synchroniser arrays are ordinary
      // flops, not RAM, so they are reset like any other state; a mid-settle
      // reset must discard partial progress.
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= SYNC_RESET;
        cnt_q[i]  <= '0;
      end
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples the
      // pre-edge value of its source and the synchroniser really shifts.
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], buttons[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      ready_q    <= |(pressed_d | released_d);
    end
  end

  assign level        = level_q;
  assign result       = level_q;
  assign pressed      = pressed_q;
  assign released     = released_q;
  assign result_ready = ready_q;

endmodule

// File: tb/tb_debounce_multi_channel_1.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi_channel_1
//
// Directed bench for debounce_multi_channel_1 with CNT_BITS=3 (N=8) and
// SYNC_STAGES=2, so a held input change shows on level after 10 edges.
// Two instances share clk/reset_n: one active-high, one active-low.
// -----------------------------------------------------------------------------
module tb_debounce_multi_channel_1;

  localparam int CH = 4;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] buttons, level, pressed, released, result;
  logic          result_ready;
  logic [CH-1:0] buttons_n, level_n, pressed_n, released_n, result_n;
  logic          ready_n;

  int checks = 0;
  int errors = 0;

  debounce_multi_channel_1 #(
    .CHANNELS(CH), .CNT_BITS(3), .SYNC_STAGES(2), .ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .level(level),
    .pressed(pressed), .released(released), .result(result),
    .result_ready(result_ready)
  );

  debounce_multi_channel_1 #(
    .CHANNELS(CH), .CNT_BITS(3), .SYNC_STAGES(2), .ACTIVE_HIGH(0)
  ) dut_low (
    .clk(clk), .reset_n(reset_n), .buttons(buttons_n), .level(level_n),
    .pressed(pressed_n), .released(released_n), .result(result_n),
    .result_ready(ready_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one posedge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    buttons   = '0;
    buttons_n = '1;
    repeat (3) tick();
    check("rst_level",    level,        4'h0);
    check("rst_pressed",  pressed,      4'h0);
    check("rst_released", released,     4'h0);
    check("rst_result",   result,       4'h0);
    check("rst_ready",    result_ready, 1'b0);
    check("rst_level_n",  level_n,      4'h0);
    reset_n = 1'b1;
    repeat (4) tick();
    check("post_rst_pulses",   pressed | released,     4'h0);
    check("post_rst_ready",    result_ready,           1'b0);
    check("post_rst_level_n",  level_n,                4'h0);
    check("post_rst_pulses_n", pressed_n | released_n, 4'h0);

    // 1: single press on channel 0, level after edge 9
    buttons[0] = 1'b1;
    repeat (9) tick();
    check("t1_level_edge8", level,        4'h0);
    check("t1_ready_edge8", result_ready, 1'b0);
    tick();
    check("t1_level_edge9",    level,        4'h1);
    check("t1_pressed_edge9",  pressed,      4'h1);
    check("t1_released_edge9", released,     4'h0);
    check("t1_ready_edge9",    result_ready, 1'b1);
    check("t1_result_edge9",   result,       4'h1);
    tick();
    check("t1_pressed_edge10", pressed,      4'h0);
    check("t1_ready_edge10",   result_ready, 1'b0);
    check("t1_level_edge10",   level,        4'h1);

    // 2: channel 1 bounces with 7-cycle bursts, never reaching N
    buttons[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t2_level_a", level,   4'h1);
      check("t2_pulse_a", pressed | released, 4'h0);
    end
    buttons[1] = 1'b0;
    tick();
    buttons[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t2_level_b", level, 4'h1);
      check("t2_pulse_b", pressed | released, 4'h0);
    end
    buttons[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t2_level_c", level, 4'h1);
      check("t2_ready_c", result_ready, 1'b0);
    end

    // 3: channel 2 press then release, release debounced symmetrically
    buttons[2] = 1'b1;
    repeat (10) tick();
    check("t3_press_level", level,   4'h5);
    check("t3_press_pulse", pressed, 4'h4);
    tick();
    buttons[2] = 1'b0;
    repeat (9) tick();
    check("t3_rel_level_early", level,    4'h5);
    check("t3_rel_pulse_early", released, 4'h0);
    tick();
    check("t3_released",   released,     4'h4);
    check("t3_rel_level",  level,        4'h1);
    check("t3_rel_press",  pressed,      4'h0);
    check("t3_rel_ready",  result_ready, 1'b1);
    tick();
    check("t3_released_end", released,     4'h0);
    check("t3_ready_end",    result_ready, 1'b0);

    // 4: channels 0 and 3 pressed on the same edge
    buttons[0] = 1'b0;
    repeat (12) tick();
    check("t4_idle_level", level, 4'h0);
    buttons = 4'b1001;
    repeat (9) tick();
    check("t4_pressed_early", pressed, 4'h0);
    tick();
    check("t4_pressed", pressed,      4'h9);
    check("t4_ready",   result_ready, 1'b1);
    check("t4_level",   level,        4'h9);
    check("t4_result",  result,       4'h9);
    tick();
    check("t4_pressed_end", pressed,      4'h0);
    check("t4_ready_end",   result_ready, 1'b0);

    // 5: reset mid-settle (count 5 on channel 1) discards the window
    buttons = 4'b0010;
    repeat (7) tick();
    check("t5_before_rst", level, 4'h9);
    reset_n = 1'b0;
    #1;
    check("t5_rst_level",  level,              4'h0);
    check("t5_rst_pulses", pressed | released, 4'h0);
    check("t5_rst_ready",  result_ready,       1'b0);
    repeat (2) tick();
    check("t5_rst_hold_level", level, 4'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("t5_resettle_level", level,              4'h0);
      check("t5_resettle_pulse", pressed | released, 4'h0);
    end
    tick();
    check("t5_level",   level,        4'h2);
    check("t5_pressed", pressed,      4'h2);
    check("t5_ready",   result_ready, 1'b1);
    tick();
    check("t5_pressed_end", pressed, 4'h0);

    // 6: active-low instance, channel 0 pin driven low
    check("t6_idle_level_n", level_n, 4'h0);
    buttons_n = 4'b1110;
    repeat (9) tick();
    check("t6_level_n_early",   level_n,   4'h0);
    check("t6_pressed_n_early", pressed_n, 4'h0);
    tick();
    check("t6_level_n",    level_n,    4'h1);
    check("t6_pressed_n",  pressed_n,  4'h1);
    check("t6_ready_n",    ready_n,    1'b1);
    check("t6_result_n",   result_n,   4'h1);
    tick();
    check("t6_pressed_n_end", pressed_n, 4'h0);
    check("t6_ready_n_end",   ready_n,   1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
